// File: rtl/rs_alu_if.sv
// Signal bundle for the ALU reservation station: issue port, both CDBs, flush
// and the dispatch handshake toward the ALU.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif
`ifndef AluOpBus
`define AluOpBus 4:0
`endif

interface rs_alu_if #(
    parameter int ROB_W = `ROB_ID_WIDTH,
    parameter int OP_W  = $bits(logic [`AluOpBus])
);
    logic             flush;

    logic             rs_alu_we;
    logic [OP_W-1:0]  rs_alu_op;
    logic [31:0]      rs_alu_vj;
    logic [31:0]      rs_alu_vk;
    logic [ROB_W-1:0] rs_alu_qj;
    logic [ROB_W-1:0] rs_alu_qk;
    logic             rs_alu_qj_valid;
    logic             rs_alu_qk_valid;
    logic [ROB_W-1:0] rs_alu_dest;
    logic [31:0]      rs_alu_imm;
    logic [31:0]      rs_alu_pc;
    logic [31:0]      rs_alu_pred_target;
    logic             rs_alu_full;

    logic             cdb0_valid;
    logic [ROB_W-1:0] cdb0_rob_id;
    logic [31:0]      cdb0_value;
    logic             cdb1_valid;
    logic [ROB_W-1:0] cdb1_rob_id;
    logic [31:0]      cdb1_value;

    logic             alu_valid;
    logic             alu_ready;
    logic [OP_W-1:0]  alu_op;
    logic [31:0]      alu_vj;
    logic [31:0]      alu_vk;
    logic [31:0]      alu_imm;
    logic [31:0]      alu_pc;
    logic [31:0]      alu_pred_target;
    logic [ROB_W-1:0] alu_dest;

    modport master (
        output flush,
        output rs_alu_we, rs_alu_op, rs_alu_vj, rs_alu_vk, rs_alu_qj, rs_alu_qk,
        output rs_alu_qj_valid, rs_alu_qk_valid, rs_alu_dest,
        output rs_alu_imm, rs_alu_pc, rs_alu_pred_target,
        input  rs_alu_full,
        output cdb0_valid, cdb0_rob_id, cdb0_value,
        output cdb1_valid, cdb1_rob_id, cdb1_value,
        input  alu_valid,
        output alu_ready,
        input  alu_op, alu_vj, alu_vk, alu_imm, alu_pc, alu_pred_target, alu_dest
    );

    modport slave (
        input  flush,
        input  rs_alu_we, rs_alu_op, rs_alu_vj, rs_alu_vk, rs_alu_qj, rs_alu_qk,
        input  rs_alu_qj_valid, rs_alu_qk_valid, rs_alu_dest,
        input  rs_alu_imm, rs_alu_pc, rs_alu_pred_target,
        output rs_alu_full,
        input  cdb0_valid, cdb0_rob_id, cdb0_value,
        input  cdb1_valid, cdb1_rob_id, cdb1_value,
        output alu_valid,
        input  alu_ready,
        output alu_op, alu_vj, alu_vk, alu_imm, alu_pc, alu_pred_target, alu_dest
    );
endinterface

// File: rtl/rs_alu.sv
// ALU reservation station: holds issued ops until both operands arrive on a CDB,
// then dispatches the lowest-index ready entry to the ALU.
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif
`ifndef AluOpBus
`define AluOpBus 4:0
`endif

module rs_alu #(
    parameter int RS_DEPTH = 8,
    parameter int ROB_W    = `ROB_ID_WIDTH,
    parameter int OP_W     = $bits(logic [`AluOpBus])
) (
    input logic    clk,
    input logic    rst,
    rs_alu_if.slave bus
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] r_busy;
    logic [RS_DEPTH-1:0] r_qjValid;
    logic [RS_DEPTH-1:0] r_qkValid;
    logic [OP_W-1:0]     r_op         [RS_DEPTH];
    logic [31:0]         r_vj         [RS_DEPTH];
    logic [31:0]         r_vk         [RS_DEPTH];
    logic [ROB_W-1:0]    r_qj         [RS_DEPTH];
    logic [ROB_W-1:0]    r_qk         [RS_DEPTH];
    logic [ROB_W-1:0]    r_dest       [RS_DEPTH];
    logic [31:0]         r_imm        [RS_DEPTH];
    logic [31:0]         r_pc         [RS_DEPTH];
    logic [31:0]         r_predTarget [RS_DEPTH];

    logic                w_cdb0Valid;
    logic [ROB_W-1:0]    w_cdb0Tag;
    logic [31:0]         w_cdb0Value;
    logic                w_cdb1Valid;
    logic [ROB_W-1:0]    w_cdb1Tag;
    logic [31:0]         w_cdb1Value;

    logic [RS_DEPTH-1:0] w_ready;
    logic                w_full;
    logic                w_selFound;
    logic [IDX_W-1:0]    w_selIdx;
    logic [IDX_W-1:0]    w_allocIdx;
    logic                w_dispValid;
    logic                w_fire;
    logic                w_alloc;
    logic [RS_DEPTH-1:0] w_busyNext;
    logic [31:0]         w_issVj;
    logic [31:0]         w_issVk;
    logic                w_issQjValid;
    logic                w_issQkValid;

    assign w_cdb0Valid = bus.cdb0_valid;
    assign w_cdb0Tag   = bus.cdb0_rob_id;
    assign w_cdb0Value = bus.cdb0_value;
    assign w_cdb1Valid = bus.cdb1_valid;
    assign w_cdb1Tag   = bus.cdb1_rob_id;
    assign w_cdb1Value = bus.cdb1_value;

    // cdb0 is checked first so it wins when both buses carry the same tag.
    function automatic logic f_cdbHit(input logic [ROB_W-1:0] tag);
        return (w_cdb0Valid && (w_cdb0Tag == tag)) || (w_cdb1Valid && (w_cdb1Tag == tag));
    endfunction

    function automatic logic [31:0] f_cdbValue(input logic [ROB_W-1:0] tag);
        return (w_cdb0Valid && (w_cdb0Tag == tag)) ? w_cdb0Value : w_cdb1Value;
    endfunction

    assign w_ready     = r_busy & ~r_qjValid & ~r_qkValid;
    assign w_full      = &r_busy;
    assign w_dispValid = w_selFound & ~bus.flush;
    assign w_fire      = w_dispValid & bus.alu_ready;
    assign w_alloc     = bus.rs_alu_we & ~w_full & ~bus.flush;

    assign bus.rs_alu_full = w_full;
    assign bus.alu_valid   = w_dispValid;

    // Priority encoders: scanning downward leaves the lowest matching index.
    always_comb begin
        w_selFound = 1'b0;
        w_selIdx   = '0;
        w_allocIdx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_selFound = 1'b1;
                w_selIdx   = IDX_W'(i);
            end
            if (!r_busy[i]) begin
                w_allocIdx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_issVj      = bus.rs_alu_vj;
        w_issVk      = bus.rs_alu_vk;
        w_issQjValid = bus.rs_alu_qj_valid;
        w_issQkValid = bus.rs_alu_qk_valid;
        if (bus.rs_alu_qj_valid && f_cdbHit(bus.rs_alu_qj)) begin
            w_issVj      = f_cdbValue(bus.rs_alu_qj);
            w_issQjValid = 1'b0;
        end
        if (bus.rs_alu_qk_valid && f_cdbHit(bus.rs_alu_qk)) begin
            w_issVk      = f_cdbValue(bus.rs_alu_qk);
            w_issQkValid = 1'b0;
        end
    end

    // Allocation picks from registered busy bits, so it never lands on the slot being freed.
    always_comb begin
        w_busyNext = r_busy;
        if (w_fire) begin
            w_busyNext[w_selIdx] = 1'b0;
        end
        if (w_alloc) begin
            w_busyNext[w_allocIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    // Payload needs no reset; busy alone decides whether an entry means anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_alloc && (w_allocIdx == IDX_W'(i))) begin
                r_op[i]         <= bus.rs_alu_op;
                r_vj[i]         <= w_issVj;
                r_vk[i]         <= w_issVk;
                r_qj[i]         <= bus.rs_alu_qj;
                r_qk[i]         <= bus.rs_alu_qk;
                r_qjValid[i]    <= w_issQjValid;
                r_qkValid[i]    <= w_issQkValid;
                r_dest[i]       <= bus.rs_alu_dest;
                r_imm[i]        <= bus.rs_alu_imm;
                r_pc[i]         <= bus.rs_alu_pc;
                r_predTarget[i] <= bus.rs_alu_pred_target;
            end else if (r_busy[i]) begin
                if (r_qjValid[i] && f_cdbHit(r_qj[i])) begin
                    r_vj[i]      <= f_cdbValue(r_qj[i]);
                    r_qjValid[i] <= 1'b0;
                end
                if (r_qkValid[i] && f_cdbHit(r_qk[i])) begin
                    r_vk[i]      <= f_cdbValue(r_qk[i]);
                    r_qkValid[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.alu_op          = '0;
        bus.alu_vj          = '0;
        bus.alu_vk          = '0;
        bus.alu_imm         = '0;
        bus.alu_pc          = '0;
        bus.alu_pred_target = '0;
        bus.alu_dest        = '0;
        if (w_dispValid) begin
            bus.alu_op          = r_op[w_selIdx];
            bus.alu_vj          = r_vj[w_selIdx];
            bus.alu_vk          = r_vk[w_selIdx];
            bus.alu_imm         = r_imm[w_selIdx];
            bus.alu_pc          = r_pc[w_selIdx];
            bus.alu_pred_target = r_predTarget[w_selIdx];
            bus.alu_dest        = r_dest[w_selIdx];
        end
    end
endmodule

// File: tb/tb_rs_alu.sv
// Scoreboard bench for rs_alu: directed scenarios then random traffic, all
// checked against an entry-list reference model kept in the bench.
module tb_rs_alu;
    localparam int DEPTH = 8;
    localparam int RW    = 4;
    localparam int OW    = 5;

    typedef struct {
        bit          rst;
        bit          flush;
        bit          we;
        bit [OW-1:0] op;
        bit [31:0]   vj, vk, imm, pc, pt;
        bit [RW-1:0] qj, qk, dest;
        bit          pj, pk;
        bit          c0v, c1v;
        bit [RW-1:0] c0t, c1t;
        bit [31:0]   c0d, c1d;
        bit          ready;
    } stim_t;

    typedef struct {
        bit          busy;
        bit [OW-1:0] op;
        bit [31:0]   vj, vk, imm, pc, pt;
        bit [RW-1:0] qj, qk, dest;
        bit          pj, pk;
    } ent_t;

    typedef struct packed {
        logic [OW-1:0] op;
        logic [31:0]   vj, vk, imm, pc, pt;
        logic [RW-1:0] dest;
    } disp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    bit   checking;
    bit   expFull;
    bit   expValid;
    ent_t model [DEPTH];
    disp_t expQ [$];

    rs_alu_if #(.ROB_W(RW), .OP_W(OW)) bus ();

    rs_alu #(.RS_DEPTH(DEPTH), .ROB_W(RW), .OP_W(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle(input bit ready);
        stim_t s;
        s = '{default: '0};
        s.ready = ready;
        return s;
    endfunction

    function automatic stim_t wr(input bit [OW-1:0] op, input bit [31:0] vj, input bit [31:0] vk,
                                 input bit pj, input bit [RW-1:0] qj, input bit pk,
                                 input bit [RW-1:0] qk, input bit [RW-1:0] dest, input bit ready);
        stim_t s;
        s = idle(ready);
        s.we = 1'b1; s.op = op; s.vj = vj; s.vk = vk;
        s.pj = pj; s.qj = qj; s.pk = pk; s.qk = qk; s.dest = dest;
        s.imm = $urandom; s.pc = $urandom; s.pt = $urandom;
        return s;
    endfunction

    // Operand resolution from the broadcasts: cdb0 first, then cdb1.
    function automatic void lookup(input stim_t s, input bit [RW-1:0] tag,
                                   output bit hit, output bit [31:0] val);
        hit = 1'b1;
        val = 32'd0;
        if (s.c0v && s.c0t == tag) val = s.c0d;
        else if (s.c1v && s.c1t == tag) val = s.c1d;
        else hit = 1'b0;
    endfunction

    // Computes this cycle's expected outputs, queues any dispatch, then advances the model.
    task automatic modelStep(input stim_t s);
        int    sel = -1;
        int    freeIdx = -1;
        bit    hit;
        bit [31:0] val;
        ent_t  nxt [DEPTH];
        disp_t d;
        for (int i = 0; i < DEPTH; i++) begin
            if (model[i].busy && !model[i].pj && !model[i].pk && sel < 0) sel = i;
            if (!model[i].busy && freeIdx < 0) freeIdx = i;
        end
        expFull  = (freeIdx < 0);
        expValid = (sel >= 0) && !s.flush;
        if (expValid && s.ready) begin
            d.op = model[sel].op; d.vj = model[sel].vj; d.vk = model[sel].vk;
            d.imm = model[sel].imm; d.pc = model[sel].pc; d.pt = model[sel].pt;
            d.dest = model[sel].dest;
            expQ.push_back(d);
        end
        if (s.rst || s.flush) begin
            for (int i = 0; i < DEPTH; i++) model[i].busy = 1'b0;
        end else begin
            nxt = model;
            for (int i = 0; i < DEPTH; i++) begin
                if (model[i].busy && model[i].pj) begin
                    lookup(s, model[i].qj, hit, val);
                    if (hit) begin nxt[i].vj = val; nxt[i].pj = 1'b0; end
                end
                if (model[i].busy && model[i].pk) begin
                    lookup(s, model[i].qk, hit, val);
                    if (hit) begin nxt[i].vk = val; nxt[i].pk = 1'b0; end
                end
            end
            if (expValid && s.ready) nxt[sel].busy = 1'b0;
            if (s.we && freeIdx >= 0) begin
                nxt[freeIdx].busy = 1'b1;
                nxt[freeIdx].op = s.op; nxt[freeIdx].dest = s.dest;
                nxt[freeIdx].imm = s.imm; nxt[freeIdx].pc = s.pc; nxt[freeIdx].pt = s.pt;
                nxt[freeIdx].qj = s.qj; nxt[freeIdx].qk = s.qk;
                nxt[freeIdx].vj = s.vj; nxt[freeIdx].pj = s.pj;
                nxt[freeIdx].vk = s.vk; nxt[freeIdx].pk = s.pk;
                if (s.pj) begin
                    lookup(s, s.qj, hit, val);
                    if (hit) begin nxt[freeIdx].vj = val; nxt[freeIdx].pj = 1'b0; end
                end
                if (s.pk) begin
                    lookup(s, s.qk, hit, val);
                    if (hit) begin nxt[freeIdx].vk = val; nxt[freeIdx].pk = 1'b0; end
                end
            end
            model = nxt;
        end
    endtask

    task automatic checkOutput();
        tests++;
        if (bus.rs_alu_full !== expFull) begin
            fails++;
            $display("[TB] FAIL full: got %b expected %b at %0t", bus.rs_alu_full, expFull, $time);
        end
        tests++;
        if (bus.alu_valid !== expValid) begin
            fails++;
            $display("[TB] FAIL alu_valid: got %b expected %b at %0t", bus.alu_valid, expValid, $time);
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        rst                    = s.rst;
        bus.flush              = s.flush;
        bus.rs_alu_we          = s.we;
        bus.rs_alu_op          = s.op;
        bus.rs_alu_vj          = s.vj;
        bus.rs_alu_vk          = s.vk;
        bus.rs_alu_qj          = s.qj;
        bus.rs_alu_qk          = s.qk;
        bus.rs_alu_qj_valid    = s.pj;
        bus.rs_alu_qk_valid    = s.pk;
        bus.rs_alu_dest        = s.dest;
        bus.rs_alu_imm         = s.imm;
        bus.rs_alu_pc          = s.pc;
        bus.rs_alu_pred_target = s.pt;
        bus.cdb0_valid         = s.c0v;
        bus.cdb0_rob_id        = s.c0t;
        bus.cdb0_value         = s.c0d;
        bus.cdb1_valid         = s.c1v;
        bus.cdb1_rob_id        = s.c1t;
        bus.cdb1_value         = s.c1d;
        bus.alu_ready          = s.ready;
        modelStep(s);
        #3;
        if (checking) checkOutput();
    endtask

    // Monitor: pops the scoreboard on every handshake and checks idle outputs are zero.
    initial begin
        disp_t got;
        disp_t exp;
        forever begin
            @(negedge clk);
            got = {bus.alu_op, bus.alu_vj, bus.alu_vk, bus.alu_imm, bus.alu_pc,
                   bus.alu_pred_target, bus.alu_dest};
            if (bus.alu_valid === 1'b1 && bus.alu_ready === 1'b1) begin
                tests++;
                if (expQ.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL dispatch: unexpected %h at %0t", got, $time);
                end else begin
                    exp = expQ.pop_front();
                    if (got !== exp) begin
                        fails++;
                        $display("[TB] FAIL dispatch: got %h expected %h at %0t", got, exp, $time);
                    end
                end
            end else if (checking && bus.alu_valid === 1'b0) begin
                tests++;
                if (got !== '0) begin
                    fails++;
                    $display("[TB] FAIL idle_zero: got %h expected 0 at %0t", got, $time);
                end
            end
        end
    end

    initial begin
        stim_t s;
        tests    = 0;
        fails    = 0;
        checking = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '{default: '0};

        s = idle(1'b0); s.rst = 1'b1;
        applyStimulus(s);
        checking = 1'b1;
        applyStimulus(s);
        applyStimulus(idle(1'b1));

        // Ready issue: ADD 5,7 -> dest 3
        applyStimulus(wr(5'd0, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 1'b1));
        repeat (2) applyStimulus(idle(1'b1));

        // Wakeup through cdb1 two cycles after issue
        applyStimulus(wr(5'd1, 32'd0, 32'd1, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5, 1'b1));
        repeat (2) applyStimulus(idle(1'b1));
        s = idle(1'b1); s.c1v = 1'b1; s.c1t = 4'd2; s.c1d = 32'h10;
        applyStimulus(s);
        repeat (2) applyStimulus(idle(1'b1));

        // Issue-time bypass from cdb0
        s = wr(5'd2, 32'd3, 32'd0, 1'b0, 4'd0, 1'b1, 4'd4, 4'd6, 1'b1);
        s.c0v = 1'b1; s.c0t = 4'd4; s.c0d = 32'd9;
        applyStimulus(s);
        repeat (2) applyStimulus(idle(1'b1));

        // Fill all entries, ignore the ninth write, free one slot
        for (int i = 0; i < 9; i++)
            applyStimulus(wr(5'(i), 32'(i + 100), 32'(i + 200), 1'b0, 4'd0, 1'b0, 4'd0, 4'(i), 1'b0));
        applyStimulus(idle(1'b1));
        applyStimulus(idle(1'b0));
        repeat (10) applyStimulus(idle(1'b1));

        // Flush five entries together with a write
        for (int i = 0; i < 5; i++)
            applyStimulus(wr(5'd3, 32'(i), 32'(i), i[0], 4'd9, 1'b0, 4'd0, 4'(i), 1'b0));
        s = wr(5'd4, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd12, 1'b1); s.flush = 1'b1;
        applyStimulus(s);
        s = idle(1'b1); s.c0v = 1'b1; s.c0t = 4'd9; s.c0d = 32'h77;
        applyStimulus(s);
        repeat (3) applyStimulus(idle(1'b1));

        // Priority: entries 1 and 3 ready, 0 and 2 pending
        applyStimulus(wr(5'd5, 32'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 1'b0));
        applyStimulus(wr(5'd5, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 1'b0));
        applyStimulus(wr(5'd5, 32'd2, 32'd2, 1'b0, 4'd0, 1'b1, 4'd8, 4'd2, 1'b0));
        applyStimulus(wr(5'd5, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 1'b0));
        repeat (3) applyStimulus(idle(1'b1));
        s = idle(1'b1); s.c0v = 1'b1; s.c0t = 4'd7; s.c0d = 32'hA; s.c1v = 1'b1; s.c1t = 4'd8; s.c1d = 32'hB;
        applyStimulus(s);
        repeat (3) applyStimulus(idle(1'b1));

        // Same tag on both buses: cdb0 must win
        applyStimulus(wr(5'd6, 32'd0, 32'd0, 1'b1, 4'd5, 1'b1, 4'd5, 4'd7, 1'b0));
        s = idle(1'b1); s.c0v = 1'b1; s.c0t = 4'd5; s.c0d = 32'hC0; s.c1v = 1'b1; s.c1t = 4'd5; s.c1d = 32'hC1;
        applyStimulus(s);
        repeat (2) applyStimulus(idle(1'b1));

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            s = wr(5'($urandom), $urandom, $urandom, 1'($urandom), 4'($urandom_range(0, 7)),
                   1'($urandom), 4'($urandom_range(0, 7)), 4'($urandom), ($urandom_range(0, 9) < 7));
            s.we    = ($urandom_range(0, 1) == 1);
            s.flush = ($urandom_range(0, 49) == 0);
            s.rst   = ($urandom_range(0, 99) == 0);
            s.c0v   = ($urandom_range(0, 2) == 0);
            s.c0t   = 4'($urandom_range(0, 7));
            s.c0d   = $urandom;
            s.c1v   = ($urandom_range(0, 2) == 0);
            s.c1t   = 4'($urandom_range(0, 7));
            s.c1d   = $urandom;
            applyStimulus(s);
        end
        applyStimulus(idle(1'b0));

        @(negedge clk);
        #1;
        tests++;
        if (expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL pending_dispatches: got %0d outstanding expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
